// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor
// Brings a slow square wave into the clk domain. It synchronizes the input,
// produces single-cycle rise/fall enables, measures the period between rising
// edges in clk cycles, and flags an input that has stopped toggling.
module clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 26,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             period_stable,
    output logic             lost
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] LOST   = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [SYNC_STAGES:0]   prime_sr;
    logic                   primed;
    logic                   sync_out;
    logic                   rise_det;
    logic                   fall_det;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_W-1:0]       cnt;
    logic [1:0]             state;
    logic                   at_timeout;

    assign sync_out   = sync[SYNC_STAGES-1];
    // prime_sr fills with ones after reset; its top bit says prev now holds a
    // real post-reset sample, so a level that was already high is not an edge.
    assign primed     = prime_sr[SYNC_STAGES];
    assign rise_det   = primed & sync_out & ~prev;
    assign fall_det   = primed & ~sync_out & prev;
    assign at_timeout = (cnt == TIMEOUT_C);

    // Synchronizer chain, edge-detect history and priming shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            prev     <= 1'b0;
            prime_sr <= '0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], clk_in};
            prev     <= sync_out;
            prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Registered edge detection, then an output stage; the counter and state
    // machine act on rise_q so their updates land on the edge raising rise_pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_q     <= rise_det;
            fall_q     <= fall_det;
            rise_pulse <= rise_q;
            fall_pulse <= fall_q;
        end
    end

    // Period counter: restarts at 1 on every rise and saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise_q) begin
            cnt <= CNT_W'(1);
        end else if (!at_timeout) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Lock state machine; a rise always takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SEARCH;
            period        <= '0;
            period_valid  <= 1'b0;
            period_stable <= 1'b0;
            lost          <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (rise_q) state <= ARMED;
                end
                ARMED: begin
                    if (rise_q) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        state        <= RUN;
                    end else if (at_timeout) begin
                        state         <= LOST;
                        lost          <= 1'b1;
                        period_valid  <= 1'b0;
                        period_stable <= 1'b0;
                    end
                end
                RUN: begin
                    if (rise_q) begin
                        period        <= cnt;
                        period_stable <= (cnt == period);
                    end else if (at_timeout) begin
                        state         <= LOST;
                        lost          <= 1'b1;
                        period_valid  <= 1'b0;
                        period_stable <= 1'b0;
                    end
                end
                default: begin
                    if (rise_q) begin
                        state <= ARMED;
                        lost  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Testbench for clk_edge_monitor: table of square-wave segments with expected
// measurements, hand-written corner sequences, and randomized waveforms, all
// compared against an edge-timing reference model.
module tb_clk_edge_monitor;

    localparam int S       = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_in = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             period_stable;
    logic             lost;

    clk_edge_monitor #(.SYNC_STAGES(S), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clk_in(clk_in),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .period(period), .period_valid(period_valid),
        .period_stable(period_stable), .lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_period;
        bit exp_valid;
        bit exp_stable;
    } row_t;

    row_t tbl[6];

    int tests  = 0;
    int failed = 0;

    // Reference model: input samples since reset release and rise bookkeeping.
    bit samp[$];
    int n = 0;
    bit m_rise, m_fall, m_valid, m_stable, m_lost;
    int m_period, m_last, m_rises;

    int pend_edge[$];
    int pend_idx[$];
    int rises_seen = 0;
    bit seen_lost  = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            if (failed <= 40)
                $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick(input logic v);
        int gap;
        bit a, b;
        int idx;
        clk_in = v;
        @(posedge clk);
        if (rst) begin
            n = 0;
            samp.delete();
            m_rise = 0; m_fall = 0; m_valid = 0; m_stable = 0; m_lost = 0;
            m_period = 0; m_last = 0; m_rises = 0;
        end else begin
            n++;
            samp.push_back(v);
            m_rise = 0;
            m_fall = 0;
            // A rise is a 0->1 between two consecutive post-reset samples,
            // visible S+1 edges after the later sample.
            if (n >= S + 3) begin
                a = samp[n-S-2];
                b = samp[n-S-3];
                m_rise = a && !b;
                m_fall = !a && b;
            end
            if (m_rise) begin
                if (m_lost) begin
                    m_lost  = 0;
                    m_rises = 1;
                end else if (m_rises == 0) begin
                    m_rises = 1;
                end else begin
                    gap = n - m_last;
                    if (m_rises >= 2) m_stable = (gap == m_period);
                    m_period = gap;
                    m_valid  = 1;
                    m_rises++;
                end
                m_last = n;
            end else if (m_rises >= 1 && !m_lost && (n - m_last) >= TIMEOUT) begin
                m_lost   = 1;
                m_valid  = 0;
                m_stable = 0;
                m_rises  = 0;
            end
        end
        #1;
        check("rise_pulse",    int'(rise_pulse),    int'(m_rise));
        check("fall_pulse",    int'(fall_pulse),    int'(m_fall));
        check("period",        int'(period),        m_period);
        check("period_valid",  int'(period_valid),  int'(m_valid));
        check("period_stable", int'(period_stable), int'(m_stable));
        check("lost",          int'(lost),          int'(m_lost));
        if (rise_pulse === 1'b1) rises_seen++;
        if (lost === 1'b1) seen_lost = 1;
        if (pend_edge.size() > 0 && !rst && n == pend_edge[0]) begin
            void'(pend_edge.pop_front());
            idx = pend_idx.pop_front();
            check($sformatf("row%0d_period", idx), int'(period), tbl[idx].exp_period);
            check($sformatf("row%0d_valid", idx), int'(period_valid), int'(tbl[idx].exp_valid));
            check($sformatf("row%0d_stable", idx), int'(period_stable), int'(tbl[idx].exp_stable));
        end
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1;
        tick(v);
        tick(v);
        rst = 1'b0;
        pend_edge.delete();
        pend_idx.delete();
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < hi; k++) tick(1'b1);
            for (int k = 0; k < lo; k++) tick(1'b0);
        end
    endtask

    task automatic wait_rise(input logic v, input string name);
        bit ok = 0;
        for (int k = 0; k < 8; k++) begin
            tick(v);
            if (rise_pulse === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        int lat, lr, lk, cnt0;
        tbl[0] = '{hi: 2, lo: 2, reps: 4, exp_period: 4, exp_valid: 1, exp_stable: 1};
        tbl[1] = '{hi: 4, lo: 4, reps: 3, exp_period: 8, exp_valid: 1, exp_stable: 1};
        tbl[2] = '{hi: 3, lo: 3, reps: 2, exp_period: 6, exp_valid: 1, exp_stable: 0};
        tbl[3] = '{hi: 3, lo: 3, reps: 1, exp_period: 6, exp_valid: 1, exp_stable: 1};
        tbl[4] = '{hi: 1, lo: 1, reps: 3, exp_period: 2, exp_valid: 1, exp_stable: 1};
        tbl[5] = '{hi: 5, lo: 2, reps: 3, exp_period: 7, exp_valid: 1, exp_stable: 1};

        // Reset with clk_in high: outputs clear, no rise after release.
        do_reset(1'b1);
        check("reset_rise",   int'(rise_pulse),    0);
        check("reset_period", int'(period),        0);
        check("reset_valid",  int'(period_valid),  0);
        check("reset_lost",   int'(lost),          0);
        cnt0 = rises_seen;
        for (int k = 0; k < 20; k++) tick(1'b1);
        check("high_release_rises", rises_seen - cnt0, 0);
        check("high_release_valid", int'(period_valid), 0);

        // Latency and pulse width.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) tick(1'b0);
        tick(1'b1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            if (rise_pulse === 1'b1) begin lat = k; break; end
        end
        check("rise_latency", lat, S + 1);
        tick(1'b1);
        check("rise_width", int'(rise_pulse), 0);
        tick(1'b0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0);
            if (fall_pulse === 1'b1) begin lat = k; break; end
        end
        check("fall_latency", lat, S + 1);

        // Table-driven square-wave segments.
        do_reset(1'b0);
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                if (r == tbl[i].reps - 1) begin
                    pend_edge.push_back(n + 1 + S + 1);
                    pend_idx.push_back(i);
                end
                square(tbl[i].hi, tbl[i].lo, 1);
            end
        end
        for (int k = 0; k < 4; k++) tick(1'b0);
        check("table_flushed", pend_edge.size(), 0);

        // Loss of input after lock, then recovery.
        do_reset(1'b0);
        tick(1'b0);
        tick(1'b0);
        square(2, 2, 4);
        lr = -1;
        lk = -1;
        for (int k = 0; k < 40; k++) begin
            tick(1'b0);
            if (rise_pulse === 1'b1) lr = k;
            if (lost === 1'b1) begin lk = k; break; end
        end
        check("lost_delay", lk - lr, TIMEOUT);
        check("lost_period_held", int'(period), 4);
        check("lost_valid", int'(period_valid), 0);
        check("lost_stable", int'(period_stable), 0);
        tick(1'b1);
        wait_rise(1'b1, "recover_rise1_seen");
        check("recover_lost_cleared", int'(lost), 0);
        check("recover_armed_valid", int'(period_valid), 0);
        for (int k = 0; k < 3; k++) tick(1'b0);
        tick(1'b1);
        wait_rise(1'b1, "recover_rise2_seen");
        check("recover_valid", int'(period_valid), 1);
        check("recover_period", int'(period), 7);

        // Rise on the exact timeout cycle.
        do_reset(1'b0);
        tick(1'b0);
        tick(1'b0);
        square(2, 2, 3);
        seen_lost = 0;
        for (int k = 0; k < TIMEOUT - 4; k++) tick(1'b0);
        tick(1'b1);
        wait_rise(1'b1, "edge_timeout_rise_seen");
        check("edge_timeout_period", int'(period), TIMEOUT);
        check("edge_timeout_no_lost", int'(seen_lost), 0);

        // One-cycle reset during RUN with clk_in high.
        do_reset(1'b0);
        tick(1'b0);
        tick(1'b0);
        square(2, 2, 4);
        tick(1'b1);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        check("midrst_rise",   int'(rise_pulse),    0);
        check("midrst_fall",   int'(fall_pulse),    0);
        check("midrst_period", int'(period),        0);
        check("midrst_valid",  int'(period_valid),  0);
        check("midrst_stable", int'(period_stable), 0);
        check("midrst_lost",   int'(lost),          0);
        cnt0 = rises_seen;
        for (int k = 0; k < 10; k++) tick(1'b1);
        check("midrst_no_spurious", rises_seen - cnt0, 0);
        for (int k = 0; k < 3; k++) tick(1'b0);
        tick(1'b1);
        wait_rise(1'b1, "relock_rise1_seen");
        check("relock_first_valid", int'(period_valid), 0);
        for (int k = 0; k < 2; k++) tick(1'b0);
        tick(1'b1);
        wait_rise(1'b1, "relock_rise2_seen");
        check("relock_valid", int'(period_valid), 1);
        check("relock_period", int'(period), 6);

        // Randomized waveforms against the reference model.
        do_reset(1'b0);
        tick(1'b0);
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                tick(1'($urandom_range(0, 1)));
                rst = 1'b0;
            end
            if ($urandom_range(0, 5) == 0)
                for (int k = 0; k < int'($urandom_range(10, 25)); k++) tick(1'b0);
            square(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
                   int'($urandom_range(1, 4)));
        end
        for (int k = 0; k < 5; k++) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard stop so the bench cannot run away.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
